qam_symbol_mapper: RTL
======================

// Module: qam_symbol_mapper
// PURPOSE
//  Serial-to-parallel symbol mapper feeding the carrier mixer stage.
//  Accepts a serial bit stream under valid/ready and pairs bits into QPSK symbols {sin sign, cos sign}.
//  Buffers symbols in a small FIFO and presents one symbol per symbol strobe (en_clk from main_cntr)
//  as elojel_sin/elojel_cos. Tracks starvation.
// PARAMETERS
//  FIFO_DEPTH  8      symbol FIFO depth; power of 2, >=2
//  IDLE_SYM    2'b00  {sin,cos} driven when no data symbol is available
// PORTS
//  clk           in   1              system clock
//  rst           in   1              reset, asynchronous, active-high
//  bit_in        in   1              serial data bit
//  bit_valid     in   1              bit_in valid
//  bit_ready     out  1              mapper accepts bit this cycle
//  en            in   1              symbol strobe, 1-cycle pulse per symbol period
//  elojel_sin    out  1              sine sign of current symbol (1 = negate)
//  elojel_cos    out  1              cosine sign of current symbol
//  sym_valid     out  1              1 = current symbol is data, 0 = IDLE_SYM fill
//  underflow     out  1              sticky: strobe hit empty FIFO while in RUN
//  underflow_clr in   1              synchronous clear of underflow
//  fill_level    out  $clog2(D)+1    FIFO occupancy in symbols
// BEHAVIOUR
//  Reset: FIFO empty, pair-half flag 0, state IDLE, {elojel_sin,elojel_cos}=IDLE_SYM,
//   sym_valid=0, underflow=0, fill_level=0. Reset mid-operation discards partial pair and FIFO contents.
//  Bit transfer on bit_valid & bit_ready. First bit of pair -> sin sign (held in half reg), second -> cos.
//  bit_ready = ~(half & full): first bit always accepted; second only if FIFO has space.
//  Push on second-bit transfer: writes {half_bit, bit_in}. fill_level registered, updates the cycle after.
//  Pop on en & ~empty. Push and pop in the same cycle: both occur, fill_level unchanged.
//  full/empty derived from registered occupancy; ready is not bypassed from a same-cycle pop.
//  Outputs register 1 clk after en sampled high; held constant between strobes.
//  FSM (evaluated only when en=1):
//   IDLE    : empty -> stay, drive IDLE_SYM, sym_valid=0; ~empty -> pop, RUN.
//   RUN     : ~empty -> pop, stay; empty -> STARVED, drive IDLE_SYM, sym_valid=0, set underflow.
//   STARVED : ~empty -> pop, RUN; empty -> stay, drive IDLE_SYM.
//  underflow: set on RUN->STARVED edge; underflow_clr clears; set wins over simultaneous clr.
//  FIFO pointers wrap modulo FIFO_DEPTH; occupancy counter is separate, range 0..FIFO_DEPTH.
// CONFIGURATION
//  QAM_MAPPER_PRBS_EN defined: adds input prbs_sel. When prbs_sel=1, bit source is an internal PRBS7
//   (x^7+x^6+1, seed 7'h7F at reset), one bit per cycle when the transfer condition holds.
//   bit_ready=0 externally; bit_in/bit_valid are ignored. Switching prbs_sel mid-pair keeps the half bit.
//  Undefined: no prbs_sel port, no LFSR logic; external stream only.
// STRUCTURE
//  Shared include qam_defs.vh: symbol width (2), IDLE_SYM default, state encodings
//   (ST_IDLE=2'd0, ST_RUN=2'd1, ST_STARVED=2'd2), PRBS7 taps/seed.
//  Sub-module sym_fifo: synchronous FIFO, 2-bit data, FIFO_DEPTH.
//   Ports: push, pop, din, dout, full, empty, count.
//  Pairing, FSM, output regs, and optional LFSR stay in qam_symbol_mapper.
// TESTING
//  1. Reset, en every 4 clk, no bits -> outputs 00, sym_valid=0, underflow=0, state IDLE.
//  2. Bits 1,0,0,1,1,1 then strobes -> symbols {1,0},{0,1},{1,1} on successive strobes,
//     each 1 clk after en; sym_valid=1.
//  3. Push 8 symbols (DEPTH=8), no en -> fill_level=8; bit_ready=1 for next first bit,
//     0 for second; accepted after one en pop.
//  4. Drain FIFO while in RUN -> next en gives IDLE_SYM, sym_valid=0, underflow=1;
//     stays 1 until underflow_clr; clr with simultaneous set -> remains 1.
//  5. Second bit accepted in same cycle as en pop, FIFO half full -> fill_level unchanged.
//  6. Assert rst after 1 bit of a pair, then send 0,1 -> first symbol out is {0,1}.
//     With QAM_MAPPER_PRBS_EN, prbs_sel=1 -> first symbols match PRBS7 from 7'h7F.

Source files
------------

// File: rtl/qam_symbol_mapper_pkg.sv
// Shared definitions for the QPSK symbol mapper: symbol width, idle fill, FSM states, PRBS7 constants.
// No logic; combinational constants only.
// Imported by qam_symbol_mapper and sym_fifo.
package qam_symbol_mapper_pkg;

    localparam int          SYM_W        = 2;
    localparam logic [1:0]  IDLE_SYM_DEF = 2'b00;

    // Symbol-strobe FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_STARVED = 2'd2
    } state_e;

    // PRBS7, x^7 + x^6 + 1: feedback taps bits 6 and 5, all-ones seed
    localparam logic [6:0]  PRBS7_SEED   = 7'h7F;
    localparam int          PRBS7_TAP_A  = 6;
    localparam int          PRBS7_TAP_B  = 5;

    // Next PRBS7 output bit for a given register state
    function automatic logic prbs7_fb(input logic [6:0] s);
        return s[PRBS7_TAP_A] ^ s[PRBS7_TAP_B];
    endfunction

endpackage

// File: rtl/qam_symbol_mapper_sym_fifo.sv
// Synchronous show-ahead symbol FIFO, DEPTH entries of W bits.
// Latency: push visible on dout/count the cycle after; dout is the head entry combinationally.
// Backpressure: caller must not push when full nor pop when empty; flags come from the registered count.
module sym_fifo
    import qam_symbol_mapper_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = SYM_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;

    // Storage array, written on push only; contents need no reset
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

    // Pointers wrap naturally at the power-of-two depth; occupancy tracked separately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/qam_symbol_mapper.sv
// Pairs a serial bit stream into QPSK {sin,cos} sign symbols, buffers them, presents one per en strobe.
// Latency: outputs update 1 clk after en; fill_level updates 1 clk after push/pop.
// Backpressure: bit_ready drops only for a pair's second bit while the FIFO is full. Option: QAM_MAPPER_PRBS_EN.
module qam_symbol_mapper
    import qam_symbol_mapper_pkg::*;
#(
    parameter int         FIFO_DEPTH = 8,
    parameter logic [1:0] IDLE_SYM   = IDLE_SYM_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        bit_in,
    input  logic                        bit_valid,
`ifdef QAM_MAPPER_PRBS_EN
    input  logic                        prbs_sel,
`endif
    output logic                        bit_ready,
    input  logic                        en,
    output logic                        elojel_sin,
    output logic                        elojel_cos,
    output logic                        sym_valid,
    output logic                        underflow,
    input  logic                        underflow_clr,
    output logic [$clog2(FIFO_DEPTH):0] fill_level
);

    logic             half_q, half_bit_q;
    logic             full, empty, push, pop;
    logic             src_bit, src_vld, xfer;
    logic [SYM_W-1:0] fifo_dout, sym_q, sym_d;
    logic             vld_q, vld_d, uf_q, uf_d, uf_set;
    state_e           state_q, state_d;

    // A second bit can only land if there is room for the completed symbol
    logic space_ok;
    assign space_ok = !(half_q && full);

`ifdef QAM_MAPPER_PRBS_EN
    logic [6:0] lfsr_q;

    // Internal PRBS7 replaces the external stream while selected
    assign src_vld   = prbs_sel ? 1'b1 : bit_valid;
    assign src_bit   = prbs_sel ? prbs7_fb(lfsr_q) : bit_in;
    assign bit_ready = space_ok && !prbs_sel;

    // LFSR advances only when its bit is actually consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 lfsr_q <= PRBS7_SEED;
        else if (prbs_sel && xfer) lfsr_q <= {lfsr_q[5:0], prbs7_fb(lfsr_q)};
    end
`else
    assign src_vld   = bit_valid;
    assign src_bit   = bit_in;
    assign bit_ready = space_ok;
`endif

    assign xfer = src_vld && space_ok;
    assign push = xfer && half_q;
    assign pop  = en && !empty;

    // Pair tracking: first bit parks in the half register as the sin sign
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            half_q     <= 1'b0;
            half_bit_q <= 1'b0;
        end else if (xfer) begin
            half_q <= !half_q;
            if (!half_q) half_bit_q <= src_bit;
        end
    end

    sym_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (SYM_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({half_bit_q, src_bit}),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .count (fill_level)
    );

    // Strobe FSM: choose the next presented symbol and detect RUN->STARVED
    always_comb begin
        state_d = state_q;
        sym_d   = sym_q;
        vld_d   = vld_q;
        uf_set  = 1'b0;
        if (en) begin
            if (!empty) begin
                sym_d   = fifo_dout;
                vld_d   = 1'b1;
                state_d = ST_RUN;
            end else begin
                sym_d = IDLE_SYM;
                vld_d = 1'b0;
                case (state_q)
                    ST_RUN: begin
                        state_d = ST_STARVED;
                        uf_set  = 1'b1;
                    end
                    ST_STARVED: state_d = ST_STARVED;
                    default:    state_d = ST_IDLE;
                endcase
            end
        end
        uf_d = uf_set || (uf_q && !underflow_clr);
    end

    // State and output registers, held between strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sym_q   <= IDLE_SYM;
            vld_q   <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sym_q   <= sym_d;
            vld_q   <= vld_d;
            uf_q    <= uf_d;
        end
    end

    assign elojel_sin = sym_q[1];
    assign elojel_cos = sym_q[0];
    assign sym_valid  = vld_q;
    assign underflow  = uf_q;

endmodule
